// File: rtl/bus_terminal_pkg.sv
// bus_terminal_pkg
//   Shared definitions for the bus terminal endpoint: width of the
//   destination-ID field, default broadcast address, the FIFO control
//   state encoding and a helper that extracts the destination ID from a
//   packet of any width up to PKT_MAX_W bits.
package bus_terminal_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_DEF = 8'hFF;

  // Widest packet the dest_of() helper can handle.
  localparam int PKT_MAX_W = 64;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

  // Destination ID = top ID_W bits of a pkt_w-bit packet. The packet is
  // passed zero-extended to PKT_MAX_W bits.
  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                               input int pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bus_term_fifo.sv
// bus_term_fifo
//   First-word fall-through FIFO with an EMPTY/PARTIAL/FULL control FSM.
//   The head is visible on rd_data while rd_valid=1 and reads as zero
//   when empty. Fullness/emptiness come from the registered state only,
//   so a write while full is rejected even if a read happens that cycle.
// Ports:
//   clk       clock
//   reset     synchronous, active-low reset (empties the FIFO)
//   wr_en     write request; accepted when wr_ready=1
//   wr_data   data to write
//   wr_ready  FIFO not full
//   rd_valid  FIFO not empty
//   rd_data   current head (0 when empty)
//   rd_en     consume the head; ignored when empty
module bus_term_fifo
  import bus_terminal_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [width-1:0] rd_data,
  input  logic             rd_en
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(depth);

  fifo_state_t      state_reg, state_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [width-1:0] mem [depth];
  logic             wr_fire, rd_fire;

  // Status flags are decoded straight from the registered state.
  assign wr_ready = (state_reg != FULL);
  assign rd_valid = (state_reg != EMPTY);

  assign wr_fire    = wr_en & wr_ready;
  assign rd_fire    = rd_en & rd_valid;
  assign count_next = count_reg + CNT_W'(wr_fire) - CNT_W'(rd_fire);

  assign rd_data = rd_valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= EMPTY;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      // Depth is a power of two, so natural pointer overflow is the wrap.
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_fire) mem[wr_ptr_reg] <= wr_data;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      EMPTY:   if (wr_fire) state_next = PARTIAL;
      PARTIAL: begin
        if (count_next == DEPTH_CNT)  state_next = FULL;
        else if (count_next == '0)    state_next = EMPTY;
      end
      FULL:    if (rd_fire) state_next = PARTIAL;
      default: state_next = EMPTY;
    endcase
  end

endmodule

// File: rtl/bus_terminal_if.sv
// bus_terminal_if
//   Device-side endpoint of the bs_gnrtr_n_rbtr bus. Host writes go into a
//   TX FIFO presented to the bus via pndng/D_pop; bus pushes addressed to
//   this terminal (or to the broadcast address) are queued in an RX FIFO
//   for the host. Both FIFOs are first-word fall-through.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   tx_valid/tx_data    host write; tx_ready = TX FIFO not full
//   pndng/D_pop/pop     TX head offered to the bus, pop consumes it
//   push/D_push         packet delivered by the bus
//   rx_valid/rx_data    RX head for the host, rx_ready consumes it
//   pop_err             sticky: pop seen while pndng=0 (cleared by reset)
// Optional (macro BUS_TERMINAL_STATS_EN): 16-bit saturating counters
//   tx_cnt (bus pops), rx_cnt (RX accepts), filt_cnt (filtered pushes),
//   ovf_cnt (pushes dropped on RX overflow).
module bus_terminal_if
  import bus_terminal_pkg::*;
#(
  parameter int              pckg_sz   = 16,
  parameter int              fifo_size = 8,
  parameter logic [ID_W-1:0] id        = 8'h00,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_valid,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_ready,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic               pop_err
`ifdef BUS_TERMINAL_STATS_EN
  ,
  output logic [15:0]        tx_cnt,
  output logic [15:0]        rx_cnt,
  output logic [15:0]        filt_cnt,
  output logic [15:0]        ovf_cnt
`endif
);

  logic [ID_W-1:0] dest;
  logic            match;
  logic            rx_wr_ready;
  logic            pop_err_reg;

  assign dest  = dest_of(PKT_MAX_W'(D_push), pckg_sz);
  assign match = (dest == id) || (dest == broadcast);

  bus_term_fifo #(.width(pckg_sz), .depth(fifo_size)) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (tx_valid),
    .wr_data  (tx_data),
    .wr_ready (tx_ready),
    .rd_valid (pndng),
    .rd_data  (D_pop),
    .rd_en    (pop)
  );

  bus_term_fifo #(.width(pckg_sz), .depth(fifo_size)) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push & match),
    .wr_data  (D_push),
    .wr_ready (rx_wr_ready),
    .rd_valid (rx_valid),
    .rd_data  (rx_data),
    .rd_en    (rx_ready)
  );

  always_ff @(posedge clk) begin
    if (!reset)             pop_err_reg <= 1'b0;
    else if (pop && !pndng) pop_err_reg <= 1'b1;
  end

  assign pop_err = pop_err_reg;

`ifdef BUS_TERMINAL_STATS_EN
  logic [15:0] tx_cnt_reg, rx_cnt_reg, filt_cnt_reg, ovf_cnt_reg;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_cnt_reg   <= '0;
      rx_cnt_reg   <= '0;
      filt_cnt_reg <= '0;
      ovf_cnt_reg  <= '0;
    end else begin
      tx_cnt_reg   <= sat_inc(tx_cnt_reg,   pop & pndng);
      rx_cnt_reg   <= sat_inc(rx_cnt_reg,   push & match & rx_wr_ready);
      filt_cnt_reg <= sat_inc(filt_cnt_reg, push & ~match);
      ovf_cnt_reg  <= sat_inc(ovf_cnt_reg,  push & match & ~rx_wr_ready);
    end
  end

  assign tx_cnt   = tx_cnt_reg;
  assign rx_cnt   = rx_cnt_reg;
  assign filt_cnt = filt_cnt_reg;
  assign ovf_cnt  = ovf_cnt_reg;
`else
  // Without statistics the RX full flag is only consumed inside the FIFO.
  logic unused_rx_wr_ready;
  assign unused_rx_wr_ready = rx_wr_ready;
`endif

endmodule

// File: tb/tb_bus_terminal_if.sv
// tb_bus_terminal_if
//   Bench for bus_terminal_if (pckg_sz=16, fifo_size=8, id=2). A queue-based
//   reference model tracks the TX/RX contents, pop_err and (with
//   BUS_TERMINAL_STATS_EN) the counters; a negedge process compares every
//   output against it each cycle. Directed sequences add literal checks.
module tb_bus_terminal_if;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_ready;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop = 1'b0;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready = 1'b0;
  logic        pop_err;
`ifdef BUS_TERMINAL_STATS_EN
  logic [15:0] tx_cnt, rx_cnt, filt_cnt, ovf_cnt;
`endif

  int tests = 0;
  int failed = 0;
  bit checking_en = 1'b0;

  always #5 clk = ~clk;

  bus_terminal_if #(
    .pckg_sz(16), .fifo_size(8), .id(8'h02), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .pop_err(pop_err)
`ifdef BUS_TERMINAL_STATS_EN
    , .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .filt_cnt(filt_cnt), .ovf_cnt(ovf_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_tx_q[$];
  logic [15:0] m_rx_q[$];
  bit          m_pop_err;
  logic [15:0] m_tx_cnt, m_rx_cnt, m_filt_cnt, m_ovf_cnt;

  function automatic logic [15:0] inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always @(posedge clk) begin
    int tx_n, rx_n;
    tx_n = m_tx_q.size();
    rx_n = m_rx_q.size();
    if (!reset) begin
      m_tx_q.delete();
      m_rx_q.delete();
      m_pop_err = 1'b0;
      m_tx_cnt = '0; m_rx_cnt = '0; m_filt_cnt = '0; m_ovf_cnt = '0;
    end else begin
      // Fullness/emptiness judged on the occupancy before this edge.
      if (pop) begin
        if (tx_n > 0) begin
          void'(m_tx_q.pop_front());
          m_tx_cnt = inc16(m_tx_cnt);
        end else begin
          m_pop_err = 1'b1;
        end
      end
      if (tx_valid && tx_n < 8) m_tx_q.push_back(tx_data);
      if (rx_ready && rx_n > 0) void'(m_rx_q.pop_front());
      if (push) begin
        if (D_push[15:8] == 8'h02 || D_push[15:8] == 8'hFF) begin
          if (rx_n < 8) begin
            m_rx_q.push_back(D_push);
            m_rx_cnt = inc16(m_rx_cnt);
          end else begin
            m_ovf_cnt = inc16(m_ovf_cnt);
          end
        end else begin
          m_filt_cnt = inc16(m_filt_cnt);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking_en) begin
      check("pndng",    32'(pndng),    32'(m_tx_q.size() > 0));
      check("D_pop",    32'(D_pop),    32'((m_tx_q.size() > 0) ? m_tx_q[0] : 16'h0));
      check("tx_ready", 32'(tx_ready), 32'(m_tx_q.size() < 8));
      check("rx_valid", 32'(rx_valid), 32'(m_rx_q.size() > 0));
      check("rx_data",  32'(rx_data),  32'((m_rx_q.size() > 0) ? m_rx_q[0] : 16'h0));
      check("pop_err",  32'(pop_err),  32'(m_pop_err));
`ifdef BUS_TERMINAL_STATS_EN
      check("tx_cnt",   32'(tx_cnt),   32'(m_tx_cnt));
      check("rx_cnt",   32'(rx_cnt),   32'(m_rx_cnt));
      check("filt_cnt", 32'(filt_cnt), 32'(m_filt_cnt));
      check("ovf_cnt",  32'(ovf_cnt),  32'(m_ovf_cnt));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tick();
    checking_en = 1'b1;
    tick();
    reset = 1'b1;
    check("rst_pndng",    32'(pndng),    32'd0);
    check("rst_D_pop",    32'(D_pop),    32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data",  32'(rx_data),  32'd0);
    check("rst_pop_err",  32'(pop_err),  32'd0);

    // Single write, then pop.
    tx_valid = 1'b1; tx_data = 16'h0201;
    tick();
    tx_valid = 1'b0;
    check("t1_pndng", 32'(pndng), 32'd1);
    check("t1_D_pop", 32'(D_pop), 32'h0201);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("t1_pndng_after_pop", 32'(pndng), 32'd0);
    check("t1_pop_err", 32'(pop_err), 32'd0);

    // RX filtering with id=2.
    push = 1'b1; D_push = 16'h0255; tick();
    D_push = 16'hFF11; tick();
    D_push = 16'h0377; tick();
    push = 1'b0;
    check("t2_rx_head0", 32'(rx_data), 32'h0255);
    rx_ready = 1'b1;
    tick();
    check("t2_rx_head1", 32'(rx_data), 32'hFF11);
    tick();
    rx_ready = 1'b0;
    check("t2_rx_empty", 32'(rx_valid), 32'd0);
`ifdef BUS_TERMINAL_STATS_EN
    check("t2_filt_cnt", 32'(filt_cnt), 32'd1);
    check("t2_rx_cnt",   32'(rx_cnt),   32'd2);
`endif

    // TX fill: 9 writes, the 9th rejected.
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t3_tx_ready_%0d", i), 32'(tx_ready), (i < 8) ? 32'd1 : 32'd0);
      tx_valid = 1'b1; tx_data = 16'h0100 + 16'(i);
      tick();
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_head_%0d", i), 32'(D_pop), 32'h0100 + i);
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    check("t3_pndng_end", 32'(pndng), 32'd0);

    // Write while full with a simultaneous pop is still rejected.
    tx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_data = 16'h0110 + 16'(i);
      tick();
    end
    tx_data = 16'h0199; pop = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      check($sformatf("t3b_head_%0d", i), 32'(D_pop), 32'h0110 + i);
      tick();
    end
    pop = 1'b0;
    check("t3b_pndng_end", 32'(pndng), 32'd0);

    // RX overflow.
    push = 1'b1;
    for (int i = 0; i < 9; i++) begin
      D_push = 16'h0200 + 16'(i);
      tick();
    end
    push = 1'b0;
    check("t4_rx_head", 32'(rx_data), 32'h0200);
`ifdef BUS_TERMINAL_STATS_EN
    check("t4_ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
    push = 1'b1; D_push = 16'h0299; rx_ready = 1'b1;
    tick();
    push = 1'b0;
    for (int i = 1; i < 8; i++) begin
      check($sformatf("t4_drain_%0d", i), 32'(rx_data), 32'h0200 + i);
      tick();
    end
    rx_ready = 1'b0;
    check("t4_rx_empty", 32'(rx_valid), 32'd0);

    // pop_err stickiness.
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("t5_pop_err_set", 32'(pop_err), 32'd1);
    tx_valid = 1'b1; tx_data = 16'h0A01; tick();
    tx_data = 16'h0A02; pop = 1'b1; tick();
    tx_valid = 1'b0; tick();
    pop = 1'b0;
    check("t5_pop_err_held", 32'(pop_err), 32'd1);
    check("t5_pndng", 32'(pndng), 32'd0);
`ifdef BUS_TERMINAL_STATS_EN
    check("t5_tx_cnt",   32'(tx_cnt),   32'd19);
    check("t5_rx_cnt",   32'(rx_cnt),   32'd10);
    check("t5_filt_cnt", 32'(filt_cnt), 32'd1);
    check("t5_ovf_cnt",  32'(ovf_cnt),  32'd2);
`endif
    reset = 1'b0; tick(); reset = 1'b1;
    check("t5_pop_err_clr", 32'(pop_err), 32'd0);

    // Reset mid-operation discards queued traffic.
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_data = 16'h0C00 + 16'(i);
      push = 1'b1;     D_push  = 16'h02C0 + 16'(i);
      tick();
    end
    tx_valid = 1'b0; push = 1'b0;
    check("t6_pndng_pre",    32'(pndng),    32'd1);
    check("t6_rx_valid_pre", 32'(rx_valid), 32'd1);
    reset = 1'b0; tick(); reset = 1'b1;
    check("t6_pndng",    32'(pndng),    32'd0);
    check("t6_rx_valid", 32'(rx_valid), 32'd0);
    check("t6_tx_ready", 32'(tx_ready), 32'd1);
`ifdef BUS_TERMINAL_STATS_EN
    check("t6_tx_cnt",   32'(tx_cnt),   32'd0);
    check("t6_rx_cnt",   32'(rx_cnt),   32'd0);
    check("t6_filt_cnt", 32'(filt_cnt), 32'd0);
    check("t6_ovf_cnt",  32'(ovf_cnt),  32'd0);
`endif
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_terminal_if.md
Name: bus_terminal_if

Overview:
- Synthesizable device-side endpoint of the bs_gnrtr_n_rbtr bus; the RTL counterpart of the bench's driver/monitor pair.
- Terminal side: presents queued outbound packets to the bus through pndng/D_pop and accepts bus pops.
- Receive side: captures bus pushes (push/D_push), filters them by destination ID and queues them for the local host.
- One instance per bus terminal (drvrs instances around the bus).

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID, the rest is payload.
- fifo_size, 8, depth of each of the TX and RX FIFOs; power of two, minimum 2.
- id, 0, 8-bit address of this terminal.
- broadcast, 8'hFF, destination value accepted by every terminal.

Ports:
- clk  in  1  bus clock.
- reset  in  1  synchronous, active-low reset.
- tx_valid  in  1  host write request.
- tx_data  in  pckg_sz  outbound packet.
- tx_ready  out  1  TX FIFO not full.
- pndng  out  1  TX FIFO non-empty, to the bus.
- D_pop  out  pckg_sz  TX FIFO head, to the bus.
- pop  in  1  bus consumes the head.
- push  in  1  bus delivers a packet.
- D_push  in  pckg_sz  delivered packet.
- rx_valid  out  1  RX FIFO non-empty.
- rx_data  out  pckg_sz  RX FIFO head.
- rx_ready  in  1  host consumes the RX head.
- pop_err  out  1  sticky flag: pop was seen while pndng=0.

Behaviour:
- Reset: when reset=0 at a clk edge, both FIFOs are emptied and pointers set to 0. Outputs after reset: pndng=0, D_pop=0, tx_ready=1, rx_valid=0, rx_data=0, pop_err=0. Reset mid-operation discards all queued packets.
- Both FIFOs are first-word fall-through.
  - D_pop equals the TX head combinationally while pndng=1, and 0 when the FIFO is empty.
  - rx_data behaves the same way against rx_valid.
- TX write: accepted at an edge where tx_valid & tx_ready.
  - pndng rises on the next cycle; write-to-pndng latency is 1.
  - tx_ready reflects the registered count only. A write while full is rejected even if pop occurs in the same cycle; the data is lost and no state changes.
- TX pop: at an edge with pop & pndng the read pointer advances, and the new head appears the next cycle.
  - pop with pndng=0 sets pop_err; pointers are unchanged.
  - pop_err clears only on reset.
- Simultaneous TX write and pop (not full, not empty): both take effect and the count is unchanged.
- RX capture: at an edge with push=1, dest = D_push[pckg_sz-1:pckg_sz-8].
  - If dest==id or dest==broadcast, and the RX FIFO is not full, the packet is written. rx_valid rises the next cycle.
  - If the RX FIFO is full, the packet is dropped (overflow).
  - If dest does not match, the packet is dropped (filtered).
- RX read: rx_valid & rx_ready advances the head. A push and a read in the same cycle while full still drops the push, because fullness is evaluated from the registered count.
- Pointers are log2(fifo_size) bits and wrap modulo fifo_size. The count is log2(fifo_size)+1 bits wide.
- Control is one small state machine per FIFO: EMPTY -> PARTIAL -> FULL, and back.
  - EMPTY -> PARTIAL on a write.
  - PARTIAL -> FULL when count reaches fifo_size.
  - FULL -> PARTIAL on a read.
  - PARTIAL -> EMPTY when count reaches 0.
  - pndng, tx_ready and rx_valid are decoded from the state.

Optional Feature:
- Macro: BUS_TERMINAL_STATS_EN.
- With the macro defined, four extra outputs are present, each 16 bits and saturating at 16'hFFFF, cleared by reset:
  - tx_cnt: packets popped by the bus.
  - rx_cnt: packets accepted into RX.
  - filt_cnt: packets dropped by the filter.
  - ovf_cnt: packets dropped on RX overflow.
- Without the macro these ports and their counter logic do not exist; all other behaviour is identical.

Decomposition:
- Package bus_terminal_pkg holds:
  - the ID field width constant (8) and the default broadcast value;
  - the FIFO state typedef enum {EMPTY, PARTIAL, FULL};
  - the function extracting the destination field from a packet.
- One sub-module, bus_term_fifo (FWFT, parameterized width and depth), is instantiated twice, once for TX and once for RX.

Test Plan:
- Reset, then write 16'h0201 with tx_valid for 1 cycle -> pndng=1 and D_pop=16'h0201 on the next cycle. Pulse pop -> pndng=0 the following cycle, and pop_err stays 0.
- id=2: push 16'h0255, 16'hFF11, 16'h0377 -> rx_data delivers 16'h0255 then 16'hFF11; 16'h0377 is dropped; filt_cnt=1 and rx_cnt=2 when stats are enabled.
- Write 9 packets 16'h0100..16'h0108 back-to-back with fifo_size=8 -> tx_ready=0 after 8 writes and 16'h0108 is rejected. Pop 8 times -> heads come out in order 0100..0107, then pndng=0.
- RX full: hold rx_ready=0 and push 9 matching packets -> 8 are stored and ovf_cnt=1. A push and rx_ready in the same cycle while full -> the push is dropped and count becomes 7.
- Pop with an empty TX FIFO -> pop_err=1 and it stays 1 through further traffic; a reset pulse clears it.
- Queue 3 TX and 3 RX packets, then assert reset=0 for 1 cycle -> pndng=0, rx_valid=0, tx_ready=1, and all counters read 0.
